// File: rtl/multicycle_control_irq_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, opcodes, ALU ops and PC source selects.
package multicycle_ctrl_pkg;

  typedef enum logic [4:0] {
    S_INIT     = 5'd0,
    S_FETCH    = 5'd1,
    S_DECODE   = 5'd2,
    S_ALU_EXEC = 5'd3,
    S_ALU_WB   = 5'd4,
    S_MEM_ADDR = 5'd5,
    S_MEM_RD   = 5'd6,
    S_MEM_WB   = 5'd7,
    S_MEM_WR   = 5'd8,
    S_BRANCH   = 5'd9,
    S_JUMP     = 5'd10,
    S_RFI      = 5'd11,
    S_TRAP     = 5'd12,
    S_IRQ_SAVE = 5'd13,
    S_IRQ_VEC  = 5'd14
  } state_e;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_BNE  = 4'd5;
  localparam logic [3:0] OP_J    = 4'd6;
  localparam logic [3:0] OP_JAL  = 4'd7;
  localparam logic [3:0] OP_RFI  = 4'd14;

  localparam logic [3:0] ALUOP_ADD = 4'd0;
  localparam logic [3:0] ALUOP_SUB = 4'd1;

  localparam logic [2:0] PCD_ALU    = 3'd0;
  localparam logic [2:0] PCD_ALUOUT = 3'd1;
  localparam logic [2:0] PCD_JUMP   = 3'd2;
  localparam logic [2:0] PCD_IRQ    = 3'd3;
  localparam logic [2:0] PCD_EPC    = 3'd4;
  localparam logic [2:0] PCD_TRAP   = 3'd5;

  // Last state of an instruction where a pending interrupt may be taken.
  function automatic logic can_divert(state_e s);
    return s inside {S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_RFI};
  endfunction

endpackage

// File: rtl/multicycle_control_irq_prio.sv
// Fixed-priority interrupt encoder: lowest set request index wins.
module irq_priority_encoder #(
  parameter int IRQ_LINES = 4,
  parameter int ID_W      = (IRQ_LINES > 1) ? $clog2(IRQ_LINES) : 1
) (
  input  logic [IRQ_LINES-1:0] req_i,
  output logic                 any_o,
  output logic [ID_W-1:0]      id_o
);

  always_comb begin
    any_o = |req_i;
    id_o  = '0;
    for (int i = IRQ_LINES - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/multicycle_control_irq.sv
// Multicycle processor control FSM with prioritised interrupts, RFI and illegal-opcode trap.
// Defining CTRL_STATE_DEBUG_EN adds current_state/next_state probe ports.
//
// state    | meaning
// INIT     | after reset, all controls low
// FETCH    | read instruction, PC += 2
// DECODE   | branch target precompute, dispatch on opcode
// ALU_EXEC | R-type / ADDI execute
// ALU_WB   | ALU result to register file
// MEM_ADDR | load/store address
// MEM_RD   | load read
// MEM_WB   | load data to register file
// MEM_WR   | store write
// BRANCH   | compare and conditional PC update
// JUMP     | J/JAL
// RFI      | return from interrupt (PC <- EPC)
// TRAP     | illegal opcode / RFI outside handler
// IRQ_SAVE | save EPC, acknowledge interrupt
// IRQ_VEC  | jump to interrupt vector
module multicycle_control_irq
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPC_W     = 4,
  parameter int FUNC_W    = 4,
  parameter int ALUOP_W   = 4,
  parameter int IRQ_LINES = 4,
  parameter int IRQ_ID_W  = (IRQ_LINES > 1) ? $clog2(IRQ_LINES) : 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
`ifdef CTRL_STATE_DEBUG_EN
  output logic [4:0]           current_state,
  output logic [4:0]           next_state,
`endif
  input  logic [OPC_W-1:0]     Opcode,
  input  logic [FUNC_W-1:0]    Functioncode,
  input  logic [IRQ_LINES-1:0] InterruptIn,
  output logic [ALUOP_W-1:0]   ALUOp,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 SignExt,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IorD,
  output logic                 IRegWrite,
  output logic                 GRegWrite,
  output logic [1:0]           WriteData,
  output logic [1:0]           WriteAddr,
  output logic                 PCWrite,
  output logic                 PCWriteBeq,
  output logic                 PCWriteBne,
  output logic [2:0]           PCData,
  output logic                 EPCWrite,
  output logic                 IrqAck,
  output logic [IRQ_ID_W-1:0]  IrqId,
  output logic                 InHandler
);

  state_e                state_q, state_d;
  logic [3:0]            op_q, opc4, op_cur;
  logic                  opc_hi_zero;
  logic                  irq_any;
  logic [IRQ_ID_W-1:0]   irq_idx, irq_id_q;
  logic                  in_handler_q;

  logic [ALUOP_W-1:0] alu_op_q;
  logic               alu_src_a_q, sign_ext_q, mem_read_q, mem_write_q, iord_q;
  logic               ireg_write_q, greg_write_q, pc_write_q, pc_write_beq_q, pc_write_bne_q;
  logic               epc_write_q, irq_ack_q;
  logic [1:0]         alu_src_b_q, write_data_q, write_addr_q;
  logic [2:0]         pc_data_q;

  irq_priority_encoder #(.IRQ_LINES(IRQ_LINES), .ID_W(IRQ_ID_W)) u_prio (
    .req_i (InterruptIn),
    .any_o (irq_any),
    .id_o  (irq_idx)
  );

  assign opc4        = 4'(Opcode);
  assign opc_hi_zero = ((Opcode >> 4) == '0);
  // Outputs are registered from state_d, so the live IR is only trusted on the DECODE exit edge.
  assign op_cur      = (state_q == S_DECODE) ? opc4 : op_q;

  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:     state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_TRAP;
        if (opc_hi_zero) begin
          case (opc4)
            OP_R, OP_ADDI: state_d = S_ALU_EXEC;
            OP_LW, OP_SW:  state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J, OP_JAL:  state_d = S_JUMP;
            OP_RFI:        state_d = in_handler_q ? S_RFI : S_TRAP;
            default:       state_d = S_TRAP;
          endcase
        end
      end
      S_ALU_EXEC: state_d = S_ALU_WB;
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_IRQ_SAVE: state_d = S_IRQ_VEC;
      S_TRAP, S_IRQ_VEC: state_d = S_FETCH;
      default: begin
        if (can_divert(state_q)) state_d = (irq_any && !in_handler_q) ? S_IRQ_SAVE : S_FETCH;
        else state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q        <= S_INIT;
      op_q           <= '0;
      irq_id_q       <= '0;
      in_handler_q   <= 1'b0;
      alu_op_q       <= '0;
      alu_src_a_q    <= 1'b0;
      alu_src_b_q    <= '0;
      sign_ext_q     <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      iord_q         <= 1'b0;
      ireg_write_q   <= 1'b0;
      greg_write_q   <= 1'b0;
      write_data_q   <= '0;
      write_addr_q   <= '0;
      pc_write_q     <= 1'b0;
      pc_write_beq_q <= 1'b0;
      pc_write_bne_q <= 1'b0;
      pc_data_q      <= '0;
      epc_write_q    <= 1'b0;
      irq_ack_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opc4;
      if (state_d == S_IRQ_SAVE) irq_id_q <= irq_idx;
      if (state_d == S_RFI) in_handler_q <= 1'b0;
      else if (state_d == S_TRAP || state_d == S_IRQ_VEC) in_handler_q <= 1'b1;

      alu_op_q       <= ALUOP_W'(ALUOP_ADD);
      alu_src_a_q    <= 1'b0;
      alu_src_b_q    <= 2'd0;
      sign_ext_q     <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      iord_q         <= 1'b0;
      ireg_write_q   <= 1'b0;
      greg_write_q   <= 1'b0;
      write_data_q   <= 2'd0;
      write_addr_q   <= 2'd0;
      pc_write_q     <= 1'b0;
      pc_write_beq_q <= 1'b0;
      pc_write_bne_q <= 1'b0;
      pc_data_q      <= PCD_ALU;
      epc_write_q    <= 1'b0;
      irq_ack_q      <= 1'b0;

      case (state_d)
        S_FETCH: begin
          mem_read_q   <= 1'b1;
          ireg_write_q <= 1'b1;
          pc_write_q   <= 1'b1;
          alu_src_b_q  <= 2'd1;
        end
        S_DECODE: begin
          alu_src_b_q <= 2'd3;
          sign_ext_q  <= 1'b1;
        end
        S_ALU_EXEC: begin
          alu_src_a_q <= 1'b1;
          if (op_cur == OP_R) begin
            alu_op_q <= ALUOP_W'(Functioncode);
          end else begin
            alu_src_b_q <= 2'd2;
            sign_ext_q  <= 1'b1;
          end
        end
        S_ALU_WB: begin
          greg_write_q <= 1'b1;
          write_addr_q <= (op_cur == OP_ADDI) ? 2'd1 : 2'd0;
        end
        S_MEM_ADDR: begin
          alu_src_a_q <= 1'b1;
          alu_src_b_q <= 2'd2;
          sign_ext_q  <= 1'b1;
        end
        S_MEM_RD: begin
          mem_read_q <= 1'b1;
          iord_q     <= 1'b1;
        end
        S_MEM_WB: begin
          greg_write_q <= 1'b1;
          write_data_q <= 2'd1;
          write_addr_q <= 2'd1;
        end
        S_MEM_WR: begin
          mem_write_q <= 1'b1;
          iord_q      <= 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_q    <= 1'b1;
          alu_op_q       <= ALUOP_W'(ALUOP_SUB);
          pc_data_q      <= PCD_ALUOUT;
          pc_write_beq_q <= (op_cur == OP_BEQ);
          pc_write_bne_q <= (op_cur == OP_BNE);
        end
        S_JUMP: begin
          pc_write_q <= 1'b1;
          pc_data_q  <= PCD_JUMP;
          if (op_cur == OP_JAL) begin
            greg_write_q <= 1'b1;
            write_data_q <= 2'd2;
            write_addr_q <= 2'd2;
          end
        end
        S_RFI: begin
          pc_write_q <= 1'b1;
          pc_data_q  <= PCD_EPC;
        end
        S_TRAP: begin
          epc_write_q <= 1'b1;
          pc_write_q  <= 1'b1;
          pc_data_q   <= PCD_TRAP;
        end
        S_IRQ_SAVE: begin
          epc_write_q <= 1'b1;
          irq_ack_q   <= 1'b1;
        end
        S_IRQ_VEC: begin
          pc_write_q <= 1'b1;
          pc_data_q  <= PCD_IRQ;
        end
        default: ;
      endcase
    end
  end

  assign ALUOp      = alu_op_q;
  assign ALUSrcA    = alu_src_a_q;
  assign ALUSrcB    = alu_src_b_q;
  assign SignExt    = sign_ext_q;
  assign MemRead    = mem_read_q;
  assign MemWrite   = mem_write_q;
  assign IorD       = iord_q;
  assign IRegWrite  = ireg_write_q;
  assign GRegWrite  = greg_write_q;
  assign WriteData  = write_data_q;
  assign WriteAddr  = write_addr_q;
  assign PCWrite    = pc_write_q;
  assign PCWriteBeq = pc_write_beq_q;
  assign PCWriteBne = pc_write_bne_q;
  assign PCData     = pc_data_q;
  assign EPCWrite   = epc_write_q;
  assign IrqAck     = irq_ack_q;
  assign IrqId      = irq_id_q;
  assign InHandler  = in_handler_q;

`ifdef CTRL_STATE_DEBUG_EN
  assign current_state = state_q;
  assign next_state    = state_d;
`endif

endmodule
